// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types for the ALU command issuer: command layout, opcodes and FSM states.
package alu_pkg;

    localparam int CMD_W  = 12;
    localparam int DATA_W = 32;

    // Compare-and-swap; the controller takes longer on it, but the issuer treats it like any other opcode.
    localparam logic [2:0] OP_CAS = 3'b111;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] addr1;
        logic [2:0] addr2;
        logic [2:0] addr3;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} issuer_state_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command / syscall / ready link between the issuer (master) and the register-file controller (slave).
interface alu_cmd_issuer_if;
    import alu_pkg::*;

    logic [CMD_W-1:0]  command;
    logic              syscall;
    logic              ctl_ready;
    logic [DATA_W-1:0] y;
    logic              Z;

    modport master (output command, output syscall, input ctl_ready, input y, input Z);
    modport slave  (input command, input syscall, output ctl_ready, output y, output Z);

endinterface

// File: rtl/alu_cmd_issuer_fifo.sv
// Synchronous command FIFO; pushes when full and pops when empty are dropped.
module cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued host commands to the register-file controller one at a time and reports each result.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CMD_W-1:0]        cmd_in,
    input  logic                    cmd_in_valid,
    output logic                    cmd_in_ready,
    alu_cmd_issuer_if.master        ctl,
    output logic                    res_valid,
    output logic [2:0]              res_op,
    output logic [DATA_W-1:0]       res_y,
    output logic                    res_z,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    err_clr,
    output logic [15:0]             issued_cnt
);
    localparam int WCW = $clog2(TIMEOUT + 1);

    issuer_state_t     state_q, state_d;
    cmd_t              command_q, command_d;
    cmd_t              head;
    logic              syscall_q, syscall_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic              res_valid_d;
    logic [2:0]        res_op_d;
    logic [DATA_W-1:0] res_y_d;
    logic              res_z_d;
    logic              err_set;
    logic              err_d;
    logic [15:0]       cnt_d;
    logic              pop;
    logic              full;
    logic              empty;

    cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_in_valid),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign cmd_in_ready = !full;
    assign busy         = (state_q != IDLE) || !empty;
    assign ctl.command  = command_q;
    assign ctl.syscall  = syscall_q;

    always_comb begin
        state_d     = state_q;
        command_d   = command_q;
        syscall_d   = 1'b0;
        wait_d      = wait_q;
        res_valid_d = 1'b0;
        res_op_d    = res_op;
        res_y_d     = res_y;
        res_z_d     = res_z;
        cnt_d       = issued_cnt;
        err_set     = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && ctl.ctl_ready) begin
                    pop       = 1'b1;
                    command_d = head;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                syscall_d = 1'b1;
                state_d   = PULSE;
            end
            PULSE: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wait_d = wait_q + 1'b1;
                // ready is ignored until the controller has had time to drop it after the syscall
                if (ctl.ctl_ready && (wait_q >= WCW'(SETTLE_CYCLES))) begin
                    res_valid_d = 1'b1;
                    res_op_d    = command_q.op;
                    res_y_d     = ctl.y;
                    res_z_d     = ctl.Z;
                    cnt_d       = issued_cnt + 16'd1;
                    state_d     = IDLE;
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set || (timeout_err && !err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            command_q   <= '0;
            syscall_q   <= 1'b0;
            wait_q      <= '0;
            res_valid   <= 1'b0;
            res_op      <= '0;
            res_y       <= '0;
            res_z       <= 1'b0;
            timeout_err <= 1'b0;
            issued_cnt  <= '0;
        end else begin
            state_q     <= state_d;
            command_q   <= command_d;
            syscall_q   <= syscall_d;
            wait_q      <= wait_d;
            res_valid   <= res_valid_d;
            res_op      <= res_op_d;
            res_y       <= res_y_d;
            res_z       <= res_z_d;
            timeout_err <= err_d;
            issued_cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: a transaction-timeline model checked every cycle plus literal pins.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
    localparam int TMO    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cmd_in = '0;
    logic        cmd_in_valid = 1'b0;
    logic        cmd_in_ready;
    logic        res_valid;
    logic [2:0]  res_op;
    logic [31:0] res_y;
    logic        res_z;
    logic        busy;
    logic        timeout_err;
    logic        err_clr = 1'b0;
    logic [15:0] issued_cnt;

    alu_cmd_issuer_if bus();

    alu_cmd_issuer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_in       (cmd_in),
        .cmd_in_valid (cmd_in_valid),
        .cmd_in_ready (cmd_in_ready),
        .ctl          (bus),
        .res_valid    (res_valid),
        .res_op       (res_op),
        .res_y        (res_y),
        .res_z        (res_z),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr),
        .issued_cnt   (issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] y;
        logic        z;
        int          lat;
    } res_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int sys_cyc = 0;
    res_t got[$];

    // Model state: queued commands, the command in flight and its age in cycles since it was popped.
    logic [11:0] mq[$];
    bit          m_act = 0;
    int          m_age = 0;
    logic [11:0] m_cur = '0;
    logic [11:0] m_command = '0;
    bit          m_sys = 0;
    bit          m_rv = 0;
    logic [2:0]  m_rop = '0;
    logic [31:0] m_ry = '0;
    bit          m_rz = 0;
    bit          m_err = 0;
    logic [15:0] m_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit pop_now, push_now, tset;
        m_rv = 0;
        if (!rst_n) begin
            mq.delete();
            m_act = 0; m_age = 0; m_command = '0; m_sys = 0;
            m_rop = '0; m_ry = '0; m_rz = 0; m_err = 0; m_cnt = '0;
            return;
        end
        pop_now  = !m_act && mq.size() != 0 && bus.ctl_ready;
        push_now = cmd_in_valid && mq.size() < DEPTH;
        tset = 0;
        if (m_act) begin
            // age 0 = setup, 1 = syscall pulse, age-2 = cycles spent waiting
            if ((m_age - 2) >= SETTLE && bus.ctl_ready) begin
                m_rv = 1; m_rop = m_cur[11:9]; m_ry = bus.y; m_rz = bus.Z;
                m_cnt = m_cnt + 16'd1; m_act = 0;
            end else if ((m_age - 2) == TMO - 1) begin
                tset = 1; m_act = 0;
            end else begin
                m_age++;
            end
        end
        if (tset) m_err = 1;
        else if (err_clr) m_err = 0;
        if (pop_now) begin
            m_cur = mq.pop_front(); m_command = m_cur; m_act = 1; m_age = 0;
        end
        if (push_now) mq.push_back(cmd_in);
        m_sys = m_act && m_age == 1;
    endtask

    task automatic compare();
        chk("cmd_in_ready", {31'd0, cmd_in_ready}, {31'd0, mq.size() < DEPTH});
        chk("busy", {31'd0, busy}, {31'd0, m_act || mq.size() != 0});
        chk("syscall", {31'd0, bus.syscall}, {31'd0, m_sys});
        chk("command", {20'd0, bus.command}, {20'd0, m_command});
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
        chk("res_op", {29'd0, res_op}, {29'd0, m_rop});
        chk("res_y", res_y, m_ry);
        chk("res_z", {31'd0, res_z}, {31'd0, m_rz});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
        chk("issued_cnt", {16'd0, issued_cnt}, {16'd0, m_cnt});
        if (bus.syscall === 1'b1) sys_cyc = cyc;
        if (res_valid === 1'b1) got.push_back('{res_op, res_y, res_z, cyc - sys_cyc});
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        #2;
        compare();
        @(negedge clk);
    endtask

    task automatic push(input logic [11:0] c);
        cmd_in = c;
        cmd_in_valid = 1'b1;
        cycle();
        cmd_in_valid = 1'b0;
    endtask

    task automatic wait_sys(input int maxc);
        bit ok = 0;
        for (int i = 0; i < maxc; i++) begin
            if (bus.syscall === 1'b1) begin ok = 1; break; end
            cycle();
        end
        chk("wait_syscall", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_res(input int target, input int maxc);
        bit ok = 0;
        for (int i = 0; i < maxc; i++) begin
            if (got.size() >= target) begin ok = 1; break; end
            cycle();
        end
        chk("wait_result", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int base;
        int waited;
        logic [15:0] cnt_before;
        logic [2:0] exp_ops[4];
        exp_ops = '{3'd0, 3'd2, 3'd4, 3'd6};
        bus.ctl_ready = 1'b0;
        bus.y = '0;
        bus.Z = 1'b0;

        // 1: reset while two commands are queued
        cycle(); cycle();
        rst_n = 1'b1;
        push(12'h111);
        push(12'h222);
        chk("t1_busy_queued", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_syscall", {31'd0, bus.syscall}, 32'd0);
        chk("t1_rst_busy", {31'd0, busy}, 32'd0);
        chk("t1_rst_ready", {31'd0, cmd_in_ready}, 32'd1);
        cycle();
        rst_n = 1'b1;
        bus.ctl_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("t1_no_result", got.size(), 32'd0);
        chk("t1_cnt", {16'd0, issued_cnt}, 32'd0);

        // 2: single command, controller always ready
        bus.y = 32'h0000_0007;
        push(12'h245);
        wait_sys(10);
        chk("t2_command", {20'd0, bus.command}, 32'h245);
        wait_res(1, 20);
        chk("t2_res_op", {29'd0, got[0].op}, 32'd1);
        chk("t2_res_y", got[0].y, 32'd7);
        chk("t2_sys_to_res", got[0].lat, 32'd4);
        chk("t2_cnt", {16'd0, issued_cnt}, 32'd1);

        // 3: fill the FIFO while the controller is busy, overflow push, then drain
        bus.ctl_ready = 1'b0;
        bus.y = 32'hA5A5_0001;
        base = got.size();
        push(12'h0C1);
        push(12'h5AA);
        push(12'h8FF);
        push(12'hC00);
        chk("t3_full", {31'd0, cmd_in_ready}, 32'd0);
        push(12'hBAD);
        bus.ctl_ready = 1'b1;
        wait_res(base + 4, 100);
        for (int i = 0; i < 20; i++) cycle();
        chk("t3_drained", got.size(), base + 4);
        for (int i = 0; i < 4; i++)
            if (got.size() > base + i) chk("t3_order", {29'd0, got[base + i].op}, {29'd0, exp_ops[i]});
        chk("t3_cnt", {16'd0, issued_cnt}, 32'd5);

        // 4: CAS with the controller dropping ready for six cycles
        bus.Z = 1'b1;
        bus.y = 32'd0;
        base = got.size();
        push(12'hE53);
        wait_sys(10);
        cycle();
        bus.ctl_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("t4_no_early", got.size(), base);
        bus.ctl_ready = 1'b1;
        wait_res(base + 1, 20);
        if (got.size() > base) begin
            chk("t4_res_op", {29'd0, got[base].op}, {29'd0, OP_CAS});
            chk("t4_res_z", {31'd0, got[base].z}, 32'd1);
        end

        // 5: controller never finishes -> timeout, recovery, clear
        bus.Z = 1'b0;
        bus.y = 32'h1234;
        base = got.size();
        cnt_before = issued_cnt;
        push(12'h123);
        wait_sys(10);
        bus.ctl_ready = 1'b0;
        waited = 0;
        while (timeout_err !== 1'b1 && waited < 100) begin
            cycle();
            waited++;
        end
        chk("t5_timeout_cycles", waited, TMO + 1);
        chk("t5_err", {31'd0, timeout_err}, 32'd1);
        chk("t5_cnt_kept", {16'd0, issued_cnt}, {16'd0, cnt_before});
        chk("t5_no_result", got.size(), base);
        bus.ctl_ready = 1'b1;
        push(12'h3C7);
        wait_res(base + 1, 20);
        if (got.size() > base) chk("t5_next_op", {29'd0, got[base].op}, 32'd1);
        chk("t5_cnt_next", {16'd0, issued_cnt}, {16'd0, cnt_before + 16'd1});
        chk("t5_err_sticky", {31'd0, timeout_err}, 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("t5_err_cleared", {31'd0, timeout_err}, 32'd0);

        // 6: counter wrap from 0xFFFF
        force dut.issued_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        cycle();
        release dut.issued_cnt;
        cycle();
        chk("t6_preset", {16'd0, issued_cnt}, 32'hFFFF);
        base = got.size();
        bus.y = 32'hDEAD_BEEF;
        push(12'h9A4);
        wait_res(base + 1, 20);
        chk("t6_wrap", {16'd0, issued_cnt}, 32'd0);
        if (got.size() > base) chk("t6_res_y", got[base].y, 32'hDEAD_BEEF);

        // reset during the syscall pulse drops it immediately
        push(12'h400);
        wait_sys(10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_syscall", {31'd0, bus.syscall}, 32'd0);
        chk("rst_mid_command", {20'd0, bus.command}, 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
